// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned LANE_W = 8;
  localparam int unsigned LANES  = WORD_W / LANE_W;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  typedef struct packed {
    logic              write;
    logic              is_byte;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } mem_req_t;

  // Zero-extended byte from little-endian lane (lane0 = bits 7:0).
  function automatic logic [WORD_W-1:0] lane_extract(input logic [WORD_W-1:0] word,
                                                     input logic [1:0]        lane);
    logic [LANE_W-1:0] b;
    case (lane)
      2'd0:    b = word[7:0];
      2'd1:    b = word[15:8];
      2'd2:    b = word[23:16];
      default: b = word[31:24];
    endcase
    return {{(WORD_W-LANE_W){1'b0}}, b};
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Word array with per-byte write enables, synchronous write, asynchronous read.
module dmem_ram
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64
) (
  input  logic                           clk,
  input  logic [$clog2(DEPTH_WORDS)-1:0] idx,
  input  logic [LANES-1:0]               we,
  input  logic [WORD_W-1:0]              wdata,
  output logic [WORD_W-1:0]              rdata_c
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LANES); i++) begin
      if (we[i]) mem[idx][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
    end
  end

  assign rdata_c = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Memory-stage load/store responder: latches one request, waits WAIT_CYCLES,
// then commits the access and pulses MemDoneM (with MemErrM on a rejected access).
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemReqM,
  input  logic              MemWriteM,
  input  logic              ByteM,
  input  logic [WORD_W-1:0] AddrM,
  input  logic [WORD_W-1:0] WriteDataM,
  output logic [WORD_W-1:0] ReadDataM,
  output logic              MemStallM,
  output logic              MemDoneM,
  output logic              MemErrM
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned IW = WORD_W - 2;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  mem_req_t          req_q, live_req, req_c;
  logic              latch_c, commit_c, err_c, we_en_c;
  logic [1:0]        lane_c;
  logic [LANES-1:0]  be_c;
  logic [WORD_W-1:0] ram_wdata_c, ram_rdata_c, load_c;

  assign live_req = '{write: MemWriteM, is_byte: ByteM, addr: AddrM, wdata: WriteDataM};

  // With no wait states the commit happens straight from IDLE, so use the live request there.
  assign req_c  = (state_q == S_IDLE) ? live_req : req_q;
  assign lane_c = req_c.addr[1:0];
  assign err_c  = (!req_c.is_byte && (lane_c != 2'b00)) ||
                  (req_c.addr[WORD_W-1:2] >= IW'(DEPTH_WORDS));

  assign we_en_c     = commit_c && req_c.write && !err_c && reset;
  assign be_c        = !we_en_c ? '0 : (req_c.is_byte ? (LANES'(1) << lane_c) : '1);
  assign ram_wdata_c = req_c.is_byte ? {LANES{req_c.wdata[LANE_W-1:0]}} : req_c.wdata;
  assign load_c      = req_c.is_byte ? lane_extract(ram_rdata_c, lane_c) : ram_rdata_c;

  assign MemStallM = reset && (((state_q == S_IDLE) && MemReqM) || (state_q == S_BUSY));

  dmem_ram #(.DEPTH_WORDS(DEPTH_WORDS)) u_ram (
    .clk     (clk),
    .idx     (req_c.addr[AW+1:2]),
    .we      (be_c),
    .wdata   (ram_wdata_c),
    .rdata_c (ram_rdata_c)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    latch_c  = 1'b0;
    commit_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (MemReqM) begin
          latch_c = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d  = S_DONE;
            commit_c = 1'b1;
          end else begin
            state_d = S_BUSY;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          commit_c = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      ReadDataM <= '0;
      MemDoneM  <= 1'b0;
      MemErrM   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      MemDoneM <= commit_c;
      MemErrM  <= commit_c && err_c;
      if (latch_c) req_q <= live_req;
      // Stores leave the last load result in place; rejected accesses clear it.
      if (commit_c) begin
        if (err_c)             ReadDataM <= '0;
        else if (!req_c.write) ReadDataM <= load_c;
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Randomised bench for dmem_responder with an array-based reference model and
// a per-cycle output compare; a second instance covers the zero-wait case.
module tb_dmem_responder;

  localparam int unsigned DEPTH = 64;
  localparam int unsigned W     = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req, wr, bm;
  logic [31:0] addr, wdata, rd;
  logic        stall, done, err;
  logic        req0, wr0, bm0;
  logic [31:0] addr0, wdata0, rd0;
  logic        stall0, done0, err0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_mem [DEPTH];
  logic        exp_stall, exp_done, exp_err;
  logic [31:0] exp_rd;
  bit          chk_en = 1'b0;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .reset(reset), .MemReqM(req), .MemWriteM(wr), .ByteM(bm),
    .AddrM(addr), .WriteDataM(wdata), .ReadDataM(rd), .MemStallM(stall),
    .MemDoneM(done), .MemErrM(err)
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .reset(reset), .MemReqM(req0), .MemWriteM(wr0), .ByteM(bm0),
    .AddrM(addr0), .WriteDataM(wdata0), .ReadDataM(rd0), .MemStallM(stall0),
    .MemDoneM(done0), .MemErrM(err0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of the WAIT=2 instance against the model's expected outputs.
  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(stall), 32'(exp_stall));
      check("done",  32'(done),  32'(exp_done));
      check("err",   32'(err),   32'(exp_err));
      check("rdata", rd, exp_rd);
    end
  end

  task automatic jitter();
    req   = 1'($urandom);
    wr    = 1'($urandom);
    bm    = 1'($urandom);
    addr  = $urandom;
    wdata = $urandom;
  endtask

  // One access on the WAIT=2 instance, with the expected timeline from the model.
  task automatic access(input bit is_wr, input bit is_b, input logic [31:0] a,
                        input logic [31:0] d, input bit noisy);
    bit          e;
    int          idx, lane;
    logic [31:0] nrd;
    e    = (!is_b && a[1:0] != 2'b00) || (a[31:2] >= DEPTH);
    idx  = int'(a[31:2]);
    lane = int'(a[1:0]);
    nrd  = exp_rd;
    if (e)           nrd = 32'h0;
    else if (!is_wr) nrd = is_b ? ((model_mem[idx] >> (8 * lane)) & 32'hFF) : model_mem[idx];
    @(posedge clk); #1;
    req = 1'b1; wr = is_wr; bm = is_b; addr = a; wdata = d;
    exp_stall = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    for (int k = 1; k <= int'(W); k++) begin
      @(posedge clk); #1;
      if (noisy) jitter();
    end
    @(posedge clk); #1;
    if (noisy) jitter();
    exp_stall = 1'b0; exp_done = 1'b1; exp_err = e; exp_rd = nrd;
    if (is_wr && !e) begin
      if (is_b) model_mem[idx][8*lane +: 8] = d[7:0];
      else      model_mem[idx] = d;
    end
    @(posedge clk); #1;
    req = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0;
  endtask

  // One access on the WAIT=0 instance; next request is driven right after DONE.
  task automatic acc0(input bit w, input bit b, input logic [31:0] a, input logic [31:0] d,
                      input logic [31:0] exp_r, input string nm);
    req0 = 1'b1; wr0 = w; bm0 = b; addr0 = a; wdata0 = d;
    @(negedge clk);
    check({nm, "_stall_req"}, 32'(stall0), 32'd1);
    check({nm, "_done_req"},  32'(done0),  32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({nm, "_stall_done"}, 32'(stall0), 32'd0);
    check({nm, "_done_done"},  32'(done0),  32'd1);
    check({nm, "_err"},        32'(err0),   32'd0);
    check({nm, "_rdata"},      rd0,         exp_r);
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] a;
    bit          w, b;
    reset = 1'b0;
    req = 1'b0; wr = 1'b0; bm = 1'b0; addr = '0; wdata = '0;
    req0 = 1'b0; wr0 = 1'b0; bm0 = 1'b0; addr0 = '0; wdata0 = '0;
    exp_stall = 1'b0; exp_done = 1'b0; exp_err = 1'b0; exp_rd = 32'h0;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    for (int i = 0; i < int'(DEPTH); i++) access(1'b1, 1'b0, 32'(4 * i), $urandom, 1'b0);

    // Word store then load.
    access(1'b1, 1'b0, 32'h10, 32'hDEADBEEF, 1'b0);
    access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    check("t1_load", rd, 32'hDEADBEEF);

    // Byte store into one lane, then byte and word loads.
    access(1'b1, 1'b0, 32'h10, 32'h11223344, 1'b0);
    access(1'b1, 1'b1, 32'h13, 32'h5A5A5AAA, 1'b0);
    access(1'b0, 1'b1, 32'h13, 32'h0, 1'b0);
    check("t2_ldrb", rd, 32'h000000AA);
    access(1'b0, 1'b0, 32'h10, 32'h0, 1'b0);
    check("t2_ldr", rd, 32'hAA223344);

    // Rejected accesses: misaligned word, out-of-range word and byte.
    access(1'b0, 1'b0, 32'h6, 32'h0, 1'b0);
    check("t4_misaligned_rd", rd, 32'h0);
    access(1'b1, 1'b0, 32'h400, 32'hCAFEF00D, 1'b0);
    access(1'b1, 1'b1, 32'h100, 32'h000000FF, 1'b0);
    access(1'b0, 1'b1, 32'h6, 32'h0, 1'b0);
    access(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    access(1'b0, 1'b0, 32'hFC, 32'h0, 1'b0);

    // Reset while a store is in BUSY: store dropped, outputs cleared.
    @(posedge clk); #1;
    req = 1'b1; wr = 1'b1; bm = 1'b0; addr = 32'h8; wdata = 32'h5;
    exp_stall = 1'b1; exp_done = 1'b0; exp_err = 1'b0;
    @(posedge clk); #1;
    req = 1'b0;
    #1 reset = 1'b0;
    exp_stall = 1'b0; exp_rd = 32'h0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    access(1'b0, 1'b0, 32'h8, 32'h0, 1'b0);

    // Random traffic with inputs toggling while an access is in flight.
    for (int n = 0; n < 300; n++) begin
      w = 1'($urandom);
      b = ($urandom_range(0, 2) == 0);
      a = 32'($urandom_range(0, 255));
      if (!b && $urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 15) == 0) a = $urandom;
      access(w, b, a, $urandom, 1'b1);
    end

    // Zero wait states: back-to-back requests, one stall cycle each.
    @(posedge clk); #1;
    acc0(1'b1, 1'b0, 32'h0, 32'h01020304, 32'h0,        "w0_st0");
    acc0(1'b1, 1'b0, 32'h4, 32'hA0B0C0D0, 32'h0,        "w0_st4");
    acc0(1'b0, 1'b0, 32'h0, 32'h0,        32'h01020304, "w0_ld0");
    acc0(1'b0, 1'b0, 32'h4, 32'h0,        32'hA0B0C0D0, "w0_ld4");
    acc0(1'b0, 1'b1, 32'h6, 32'h0,        32'h000000B0, "w0_ldb6");
    req0 = 1'b0;
    @(negedge clk);
    check("w0_idle_stall", 32'(stall0), 32'd0);

    repeat (2) @(posedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
